// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero bypasses the iteration and reports all-ones quotient.
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
    logic [DIVIDEND_W-1:0]   qacc_q, qacc_d;
    logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]    dsr_q, dsr_d;
    logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
    logic [DIVISOR_W:0]      part_q, part_d;
    logic                    dbz_q, dbz_d;

    // One extra bit holds the shifted partial remainder, which can reach 2*divisor-1.
    logic [DIVISOR_W:0]      shifted;
    logic [DIVISOR_W:0]      diff;
    logic                    fits;

    assign shifted = {part_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    assign fits    = (shifted >= {1'b0, dsr_q});
    assign diff    = shifted - {1'b0, dsr_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        part_d      = part_q;
        qacc_d      = qacc_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dsr_d  = divisor;
                    cnt_d  = '0;
                    part_d = '0;
                    qacc_d = '0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                part_d = fits ? diff : shifted;
                qacc_d = {qacc_q[DIVIDEND_W-2:0], fits};
                dvd_d  = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                // Results are published together with the final step.
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d     = DONE;
                    quotient_d  = qacc_d;
                    remainder_d = part_d[DIVISOR_W-1:0];
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            part_q      <= '0;
            qacc_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            part_q      <= part_d;
            qacc_q      <= qacc_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases, reset abort, random and exhaustive
// operands checked against plain integer division.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    // Last published results, expected to hold outside the DONE cycle.
    logic [DW-1:0] pq = '0;
    logic [SW-1:0] pr = '0;
    logic          pz = 1'b0;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a division (at the current negedge when now=1), checks every
    // cycle up to and including DONE; returns sitting at the DONE negedge.
    task automatic run_div(input int a, input int b, input bit now, input bit poke);
        int eq, er, ez;
        if (b == 0) begin
            eq = (1 << DW) - 1; er = 0; ez = 1;
        end else begin
            eq = a / b; er = a % b; ez = 0;
        end
        if (!now) @(negedge clk);
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = SW'(b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
        if (b != 0) begin
            for (int k = 0; k < DW; k++) begin
                @(negedge clk);
                chk("busy_run", busy, 1);
                chk("done_run", done, 0);
                chk("q_hold", quotient, pq);
                chk("r_hold", remainder, pr);
                chk("z_hold", div_by_zero, pz);
                if (poke && k == 2) begin
                    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
                end else begin
                    start = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("done_hi", done, 1);
        chk("busy_done", busy, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        pq = DW'(eq);
        pr = SW'(er);
        pz = ez[0];
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_z", div_by_zero, 0);

        @(negedge clk);
        rst_n = 1'b1;
        run_div(200, 7, 1'b1, 1'b0);
        run_div(255, 15, 1'b0, 1'b0);
        run_div(5, 9, 1'b0, 1'b0);
        run_div(0, 1, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_q_hold", quotient, pq);
        run_div(13, 0, 1'b0, 1'b0);
        run_div(100, 3, 1'b0, 1'b1);
        run_div(50, 5, 1'b1, 1'b0);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_z", div_by_zero, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        pq = '0; pr = '0; pz = 1'b0;
        run_div(9, 2, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            run_div(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                run_div(a, b, 1'(a & 1), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter DIVIDEND_W, default 8: dividend and quotient width in bits.
REQ-002 Parameter DIVISOR_W, default 4: divisor and remainder width in bits.
REQ-003 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port start  input  1: request to begin a division, sampled on a rising clk edge.
REQ-006 Port dividend  input  DIVIDEND_W: unsigned dividend, sampled with start.
REQ-007 Port divisor  input  DIVISOR_W: unsigned divisor, sampled with start.
REQ-008 Port busy  output  1: high while a division is in progress.
REQ-009 Port done  output  1: high for one cycle when results become valid.
REQ-010 Port quotient  output  DIVIDEND_W: unsigned quotient, registered.
REQ-011 Port remainder  output  DIVISOR_W: unsigned remainder, registered.
REQ-012 Port div_by_zero  output  1: set when the last accepted division had divisor 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on state, operands or outputs.
REQ-015 On acceptance, dividend and divisor SHALL be latched into internal registers; later input changes SHALL have no effect on the operation in progress.
REQ-016 Accepted start with divisor != 0: next state RUN, bit counter = 0, partial remainder (DIVISOR_W+1 bits) = 0.
REQ-017 Accepted start with divisor == 0: next state DONE directly, quotient = all ones, remainder = 0, div_by_zero = 1.
REQ-018 Each RUN cycle SHALL perform one restoring step, MSB first: shift the next dividend bit into the partial remainder; if partial >= divisor, subtract and set the quotient bit to 1, else keep it and set the bit to 0.
REQ-019 RUN SHALL last exactly DIVIDEND_W cycles; on the last RUN edge the state SHALL go to DONE.
REQ-020 On entering DONE, quotient, remainder and div_by_zero SHALL update together; div_by_zero SHALL be 0 for nonzero divisors.
REQ-021 Latency: start sampled at edge N (nonzero divisor) -> done high in the cycle after edge N+DIVIDEND_W (N+8 by default); divisor 0 -> done high in the cycle after edge N.
REQ-022 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); both SHALL never be high together.
REQ-023 DONE SHALL last one cycle, then go to IDLE; start sampled in DONE SHALL begin a new division (RUN or DONE per REQ-016/017) instead of going to IDLE.
REQ-024 quotient, remainder and div_by_zero SHALL hold their last values in IDLE and RUN until the next DONE entry.
REQ-025 Results SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.
REQ-026 Partial-remainder arithmetic SHALL use DIVISOR_W+1 bits so that no compare or subtract overflows.

Reset
REQ-027 While rst_n is low, state SHALL be IDLE and busy, done, quotient, remainder, div_by_zero and all internal registers SHALL be 0, regardless of clk.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first rising edge.

Verification
REQ-029 dividend=200, divisor=7, start one cycle -> busy for 8 cycles, then done for 1 cycle with quotient=28, remainder=4, div_by_zero=0.
REQ-030 255/15 -> quotient=17, remainder=0; 5/9 -> quotient=0, remainder=5; 0/1 -> quotient=0, remainder=0.
REQ-031 13/0 -> done in the cycle after the start edge, quotient=8'hFF, remainder=0, div_by_zero=1, busy never high.
REQ-032 Start 100/3; pulse start with 50/5 during RUN -> ignored; result quotient=33, remainder=1; then start 50/5 in the DONE cycle -> back-to-back run giving quotient=10, remainder=0.
REQ-033 Start 200/7, assert rst_n low at RUN cycle 4 -> all outputs 0 immediately, no done; after release, 9/2 -> quotient=4, remainder=1.
REQ-034 Exhaustive check of all 4096 operand pairs against REQ-025, with divisor 0 checked against REQ-017.
